// File: rtl/ecc_sram_scrub.sv
// rtl/ecc_sram_scrub.sv - SECDED SRAM with correct-on-read write-back and background scrubber
// Optional build macro ECC_ERR_INJECT_EN adds the inj_mask write-path error injection port.

module ecc_sram_scrub #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 8,
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int CW_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              scrub_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              scrub_busy
`ifdef ECC_ERR_INJECT_EN
  , input logic [CW_W-1:0]  inj_mask
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = $clog2(SCRUB_INTERVAL);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_WB} state_t;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic            single;
    logic            dbl;
  } dec_t;

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0]   cw;
    logic [DATA_W-1:0] dd;
    cw = '0;
    dd = d;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = dd[0];
        dd    = dd >> 1;
      end
    end
    // Check bit at 2^i covers every higher position with bit i set.
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) == 0) begin
        for (int q = p + 1; q < CW_W; q++) begin
          if ((q & p) != 0) cw[p] = cw[p] ^ cw[q];
        end
      end
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) d = {cw[p], d[DATA_W-1:1]};
    end
    return d;
  endfunction

  function automatic dec_t decode(input logic [CW_W-1:0] cw_in);
    dec_t r;
    int   s;
    logic po;
    s = 0;
    for (int p = 1; p < CW_W; p++) begin
      if (cw_in[p]) s = s ^ p;
    end
    po       = ^cw_in;
    r.cw     = cw_in;
    r.single = 1'b0;
    r.dbl    = 1'b0;
    if (po) begin
      // A syndrome past the last position can only come from 3+ flips.
      if (s < CW_W) begin
        r.cw     = cw_in ^ ({{(CW_W-1){1'b0}}, 1'b1} << s);
        r.single = 1'b1;
      end else begin
        r.dbl = 1'b1;
      end
    end else if (s != 0) begin
      r.dbl = 1'b1;
    end
    return r;
  endfunction

  logic [CW_W-1:0]   mem [0:DEPTH-1];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [IW-1:0]     icnt;
  logic [CW_W-1:0]   s_cw;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [CW_W-1:0]   pend_cw;
  logic [CW_W-1:0]   wr_cw;
  dec_t              dec_u, dec_s;
  logic              user_rd, pend_fire, pend_drop;
  logic              icnt_inc, icnt_clr, s_load, s_fix, s_write, s_step, s_uncorr;

`ifdef ECC_ERR_INJECT_EN
  assign wr_cw = encode(data_in) ^ inj_mask;
`else
  assign wr_cw = encode(data_in);
`endif

  assign dec_u      = decode(mem[addr]);
  assign dec_s      = decode(s_cw);
  assign user_rd    = enable && !we;
  assign pend_fire  = pend_valid && !enable;
  assign pend_drop  = pend_valid && enable && we && (addr == pend_addr);
  assign scrub_busy = (state != S_IDLE);

  // Any user access aborts a scrub step; a pending write-back only stalls it.
  always_comb begin
    state_nxt = state;
    icnt_inc  = 1'b0;
    icnt_clr  = 1'b0;
    s_load    = 1'b0;
    s_fix     = 1'b0;
    s_write   = 1'b0;
    s_step    = 1'b0;
    s_uncorr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!scrub_en) begin
          icnt_clr = 1'b1;
        end else if (!enable) begin
          if (icnt == IW'(SCRUB_INTERVAL - 1)) begin
            state_nxt = S_RD;
            icnt_clr  = 1'b1;
          end else begin
            icnt_inc = 1'b1;
          end
        end
      end
      S_RD: begin
        if (enable) begin
          state_nxt = S_IDLE;
          icnt_clr  = 1'b1;
        end else if (!pend_valid) begin
          s_load    = 1'b1;
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (enable) begin
          state_nxt = S_IDLE;
          icnt_clr  = 1'b1;
        end else if (!pend_valid) begin
          if (dec_s.single) begin
            s_fix     = 1'b1;
            state_nxt = S_WB;
          end else begin
            s_step    = 1'b1;
            s_uncorr  = dec_s.dbl;
            state_nxt = S_IDLE;
          end
        end
      end
      S_WB: begin
        if (enable) begin
          state_nxt = S_IDLE;
          icnt_clr  = 1'b1;
        end else if (!pend_valid) begin
          s_write   = 1'b1;
          s_step    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (enable && we)   mem[addr]      <= wr_cw;
    else if (pend_fire) mem[pend_addr] <= pend_cw;
    else if (s_write)   mem[ptr]       <= s_cw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      rd_valid   <= 1'b0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_addr   <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      ptr        <= '0;
      icnt       <= '0;
      s_cw       <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_cw    <= '0;
    end else begin
      rd_valid   <= 1'b0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      if (user_rd) begin
        rd_valid   <= 1'b1;
        data_out   <= extract(dec_u.cw);
        err_corr   <= dec_u.single;
        err_uncorr <= dec_u.dbl;
        if (dec_u.single || dec_u.dbl) err_addr <= addr;
        if (dec_u.single && corr_cnt != '1)   corr_cnt   <= corr_cnt + 1'b1;
        if (dec_u.dbl && uncorr_cnt != '1)    uncorr_cnt <= uncorr_cnt + 1'b1;
      end
      if (user_rd && dec_u.single) begin
        pend_valid <= 1'b1;
        pend_addr  <= addr;
        pend_cw    <= dec_u.cw;
      end else if (pend_fire || pend_drop) begin
        pend_valid <= 1'b0;
      end
      if (s_write) begin
        err_addr <= ptr;
        if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      end
      if (s_uncorr) begin
        err_addr <= ptr;
        if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
      end
      if (s_step) ptr <= ptr + 1'b1;
      if (icnt_clr)      icnt <= '0;
      else if (icnt_inc) icnt <= icnt + 1'b1;
      if (s_load)     s_cw <= mem[ptr];
      else if (s_fix) s_cw <= dec_s.cw;
    end
  end

endmodule
